// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers.
// mult/multu/div/divu run for a fixed number of busy cycles and commit HI/LO
// at the edge that ends the last busy cycle. mfhi/mflo read combinationally,
// and mthi/mtlo write directly while the unit is idle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [63:0]        mul_res;
    logic [63:0]        div_res;

    // 32x32 -> 64 product, sign-extending the operands when sgn is set.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] prod;
        sa   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod = sa * sb;
        return prod;
    endfunction

    // Returns {remainder, quotient}. The most-negative / -1 case is pinned
    // explicitly because a plain signed 32-bit divide overflows there.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        q  = '0;
        r  = '0;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign busy = (state_q == RUN);

    // Arithmetic on the latched operands; only consumed on the commit edge.
    always_comb begin
        mul_res = mul64(a_q, b_q, ~op_q[0]);
        div_res = div64(a_q, b_q, ~op_q[0]);
    end

    // Next-state logic: accept a start, count down busy cycles, commit HI/LO, handle mthi/mtlo.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (state_q == IDLE) begin
            if (start && !md_op[2]) begin
                a_d     = A;
                b_d     = B;
                op_d    = md_op[1:0];
                cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                state_d = RUN;
            end else if (md_en && !start && md_op == 3'b110) begin
                hi_d = A;
            end else if (md_en && !start && md_op == 3'b111) begin
                lo_d = A;
            end
        end else begin
            if (cnt_q <= CNT_W'(1)) begin
                cnt_d   = '0;
                state_d = IDLE;
                if (!op_q[1]) begin
                    {hi_d, lo_d} = mul_res;
                end else if (b_q != 32'd0) begin
                    {hi_d, lo_d} = div_res;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State and data registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    // HI/LO read port for mfhi/mflo.
    always_comb begin
        md_out = 32'd0;
        if (md_op == 3'b100) begin
            md_out = hi_q;
        end else if (md_op == 3'b101) begin
            md_out = lo_q;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed scenarios plus a randomized run, with an
// arithmetic reference model for HI/LO.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] md_out;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_en  (md_en),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .md_out (md_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        md_en = 1'b0;
        md_op = 3'b000;
    endtask

    // Reference: HI/LO from integer arithmetic on 64-bit values.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            3'b000: begin
                p = longint'($signed(a)) * longint'($signed(b));
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            3'b001: begin
                p = longint'({32'd0, a}) * longint'({32'd0, b});
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            3'b010, 3'b011: begin
                if (b != 0) begin
                    sa = (op == 3'b010) ? longint'($signed(a)) : longint'({32'd0, a});
                    sb = (op == 3'b010) ? longint'($signed(b)) : longint'({32'd0, b});
                    q  = sa / sb;
                    r  = sa - q * sb;
                    p  = q;
                    ref_lo = p[31:0];
                    p  = r;
                    ref_hi = p[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_hilo(input string tag);
        md_en = 1'b1;
        md_op = 3'b100;
        #1 chk({tag, " mfhi"}, md_out, ref_hi);
        md_op = 3'b101;
        #1 chk({tag, " mflo"}, md_out, ref_lo);
        idle_inputs();
        #1;
    endtask

    // Issue op in the current cycle, scramble inputs while busy, count busy cycles.
    // inject_at > 0 forces a divu 9/2 start in that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        int n;
        int exp_n;
        n     = 0;
        exp_n = op[1] ? DC : MC;
        start = 1'b1;
        md_en = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        cyc();
        while (busy === 1'b1 && n < 60) begin
            n++;
            if (n == 1) begin
                start = 1'b0;
                md_en = 1'b1;
                md_op = 3'b101;
                #1 chk({tag, " lo hidden while busy"}, md_out, ref_lo);
            end
            start = 1'($urandom_range(0, 1));
            md_en = 1'($urandom_range(0, 1));
            md_op = 3'($urandom_range(0, 7));
            A     = $urandom;
            B     = $urandom;
            if (n == inject_at) begin
                start = 1'b1;
                md_en = 1'b1;
                md_op = 3'b011;
                A     = 32'd9;
                B     = 32'd2;
            end
            cyc();
        end
        idle_inputs();
        chk({tag, " busy cycles"}, 32'(n), 32'(exp_n));
        model(op, a, b);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] v);
        start = 1'b0;
        md_en = 1'b1;
        md_op = to_hi ? 3'b110 : 3'b111;
        A     = v;
        cyc();
        idle_inputs();
        if (to_hi) ref_hi = v;
        else       ref_lo = v;
    endtask

    function automatic logic [31:0] rnd32();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [2:0] rop;
        ref_hi = '0;
        ref_lo = '0;
        reset  = 1'b1;
        start  = 1'b1;
        md_en  = 1'b1;
        md_op  = 3'b000;
        A      = 32'd5;
        B      = 32'd6;
        #12;
        chk("busy in reset", {31'd0, busy}, 32'd0);
        cyc();
        chk("start ignored in reset", {31'd0, busy}, 32'd0);
        md_op = 3'b110;
        cyc();
        reset = 1'b0;
        idle_inputs();
        cyc();
        chk("busy after release", {31'd0, busy}, 32'd0);
        check_hilo("reset");

        run_op("mult", 3'b000, 32'hFFFF_FFFF, 32'd2, 0);
        check_hilo("mult");
        chk("mult hi const", ref_hi, 32'hFFFF_FFFF);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 0);
        check_hilo("multu");
        run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 0);
        check_hilo("div");
        run_op("divu", 3'b011, 32'd7, 32'd2, 0);
        check_hilo("divu");

        mt(1'b1, 32'h1234);
        mt(1'b0, 32'h5678);
        check_hilo("mthi/mtlo");
        run_op("divu by zero", 3'b011, 32'd99, 32'd0, 0);
        check_hilo("divu by zero");

        run_op("div overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_hilo("div overflow");

        run_op("mult 3*4 busy start", 3'b000, 32'd3, 32'd4, 2);
        check_hilo("mult 3*4");

        // Reset pulsed mid-clock in busy cycle 3.
        start = 1'b1;
        md_en = 1'b1;
        md_op = 3'b000;
        A     = 32'd7;
        B     = 32'd9;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        #2 reset = 1'b1;
        #1 chk("busy cleared by async reset", {31'd0, busy}, 32'd0);
        md_en = 1'b1;
        md_op = 3'b100;
        #1 chk("hi cleared by async reset", md_out, 32'd0);
        md_op = 3'b101;
        #1 chk("lo cleared by async reset", md_out, 32'd0);
        #1 reset = 1'b0;
        idle_inputs();
        ref_hi = '0;
        ref_lo = '0;
        cyc();
        chk("busy after mid-run reset", {31'd0, busy}, 32'd0);
        check_hilo("after mid-run reset");
        run_op("mult 2*3", 3'b000, 32'd2, 32'd3, 0);
        check_hilo("mult 2*3");

        // Back-to-back: the mult is issued in the first idle cycle after the div.
        run_op("b2b div", 3'b010, 32'd100, 32'hFFFF_FFF9, 0);
        check_hilo("b2b div");
        run_op("b2b mult", 3'b000, 32'hFFFF_0000, 32'h0001_0000, 0);
        check_hilo("b2b mult");

        md_en = 1'b1;
        md_op = 3'b010;
        #1 chk("md_out other op", md_out, 32'd0);
        idle_inputs();
        #1;

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 5));
            if (rop < 3'd4) begin
                run_op($sformatf("rand%0d op%0d", i, rop), rop, rnd32(), rnd32(), 0);
            end else begin
                mt(rop == 3'd4, $urandom);
            end
            check_hilo($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
